// File: rtl/alu_pipe.sv
// Handshaked WIDTH-bit ALU: single-cycle ops land in a registered output slot,
// MUL runs a WIDTH-iteration shift-add sequence before writing the same slot.
module alu_pipe #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [3:0]       op_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] alu_o,
  output logic [3:0]       flags_o,
  output logic             err_o
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_SLL  = 4'h2;
  localparam logic [3:0] OP_SRL  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_EQ   = 4'h7;
  localparam logic [3:0] OP_SRA  = 4'h8;
  localparam logic [3:0] OP_SLT  = 4'h9;
  localparam logic [3:0] OP_SLTU = 4'hA;
  localparam logic [3:0] OP_MUL  = 4'hB;

  typedef enum logic {IDLE, BUSY} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] alu;
    logic [3:0]       flags;
    logic             err;
  } rsp_t;

  state_t             state, state_nx;
  rsp_t               rsp_q, rsp_one, rsp_mul;
  logic               vld_q;
  logic               fire, is_mul, mul_last;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   res;
  logic               c, v, err;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] mcand, acc, acc_nx;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;

  assign is_mul = (MUL_EN != 1'b0) && (op_i == OP_MUL);
  assign fire   = in_valid_i && in_ready_o;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  // in_ready only in IDLE with a free (or draining) output slot, so a finishing MUL never collides
  always_comb begin
    state_nx   = state;
    in_ready_o = 1'b0;
    case (state)
      IDLE: begin
        in_ready_o = !vld_q || out_ready_i;
        if (in_valid_i && (!vld_q || out_ready_i) && is_mul) state_nx = BUSY;
      end
      BUSY: if (mul_last) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- single-cycle datapath ----------------
  always_comb begin
    sum   = '0;
    res   = '0;
    c     = 1'b0;
    v     = 1'b0;
    err   = 1'b0;
    shamt = b_i[SHW-1:0];
    case (op_i)
      OP_ADD: begin
        sum = {1'b0, a_i} + {1'b0, b_i};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        sum = {1'b0, a_i} - {1'b0, b_i};
        res = sum[WIDTH-1:0];
        c   = sum[WIDTH];
        v   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SLL:  res = a_i << shamt;
      OP_SRL:  res = a_i >> shamt;
      OP_AND:  res = a_i & b_i;
      OP_OR:   res = a_i | b_i;
      OP_XOR:  res = a_i ^ b_i;
      OP_EQ:   res = {{(WIDTH-1){1'b0}}, a_i == b_i};
      OP_SRA:  res = $unsigned($signed(a_i) >>> shamt);
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      OP_SLTU: res = {{(WIDTH-1){1'b0}}, a_i < b_i};
      default: err = 1'b1;  // MUL never takes this path when enabled
    endcase
    rsp_one.alu   = res;
    rsp_one.flags = err ? 4'b0 : {c, res == '0, res[WIDTH-1], v};
    rsp_one.err   = err;
  end

  // ---------------- shift-add multiplier ----------------
  assign acc_nx   = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (state == BUSY) && (cnt == CNT_LAST);

  always_comb begin
    rsp_mul.alu   = acc_nx[WIDTH-1:0];
    rsp_mul.flags = {|acc_nx[2*WIDTH-1:WIDTH], acc_nx[WIDTH-1:0] == '0,
                     acc_nx[WIDTH-1], 1'b0};
    rsp_mul.err   = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (fire && is_mul) begin
      mcand  <= {{WIDTH{1'b0}}, a_i};
      mplier <= b_i;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= acc_nx;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end

  // ---------------- output slot ----------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= 1'b0;
      rsp_q <= '0;
    end else if (fire && !is_mul) begin
      vld_q <= 1'b1;
      rsp_q <= rsp_one;
    end else if (mul_last) begin
      vld_q <= 1'b1;
      rsp_q <= rsp_mul;
    end else if (out_ready_i) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid_o = vld_q;
  assign alu_o       = rsp_q.alu;
  assign flags_o     = rsp_q.flags;
  assign err_o       = rsp_q.err;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: driver pushes model results on accept,
// monitor pops and compares on every output transfer.
module tb_alu_pipe;
  localparam int W = 8;

  typedef struct packed {
    logic [7:0] alu;
    logic [3:0] flags;
    logic       err;
  } rsp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, err;
  logic [W-1:0] a_in, b_in, alu;
  logic [3:0]   op_in, flags;

  logic         nm_valid, nm_in_ready, nm_out_valid, nm_err;
  logic [W-1:0] nm_a, nm_b, nm_alu;
  logic [3:0]   nm_op, nm_flags;

  rsp_t q[$];
  int   n_vec  = 0;
  int   n_bad  = 0;
  int   rdy_mode = 1;  // 0: stall, 1: always ready, 2: random

  always #5 clk = ~clk;

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a_in), .b_i(b_in), .op_i(op_in), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .alu_o(alu), .flags_o(flags), .err_o(err)
  );

  alu_pipe #(.WIDTH(W), .MUL_EN(1'b0)) dut_nomul (
    .clk_i(clk), .rst_i(rst), .in_valid_i(nm_valid), .in_ready_o(nm_in_ready),
    .a_i(nm_a), .b_i(nm_b), .op_i(nm_op), .out_valid_o(nm_out_valid),
    .out_ready_i(1'b1), .alu_o(nm_alu), .flags_o(nm_flags), .err_o(nm_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the 8-bit operands
  function automatic rsp_t model(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int ua, ub, sa, sb, sh, r;
    logic c, v, e;
    rsp_t o;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b); sh = ub % 8;
    r = 0; c = 1'b0; v = 1'b0; e = 1'b0;
    case (op)
      4'h0: begin r = ua + ub; c = (r > 255); v = ((sa + sb) > 127) || ((sa + sb) < -128); end
      4'h1: begin r = ua - ub; c = (ua < ub); v = ((sa - sb) > 127) || ((sa - sb) < -128); end
      4'h2: r = ua << sh;
      4'h3: r = ua >> sh;
      4'h4: r = ua & ub;
      4'h5: r = ua | ub;
      4'h6: r = ua ^ ub;
      4'h7: r = int'(ua == ub);
      4'h8: r = sa >>> sh;
      4'h9: r = int'(sa < sb);
      4'hA: r = int'(ua < ub);
      4'hB: begin r = ua * ub; c = (r > 255); end
      default: e = 1'b1;
    endcase
    o.alu   = 8'(r & 255);
    o.err   = e;
    o.flags = e ? 4'b0 : {c, o.alu == 8'h00, o.alu[7], v};
    return o;
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       output int waited);
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1; a_in = a; b_in = b; op_in = op;
    #1;
    while (!in_ready) begin
      waited++;
      if (waited > 200) begin
        n_bad++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        in_valid = 1'b0;
        return;
      end
      @(negedge clk); #1;
    end
    q.push_back(model(a, b, op));
    n_vec++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor: owns out_ready, consumes and checks results, checks hold stability
  initial begin
    rsp_t e, cur, held_v;
    logic held;
    held = 1'b0; held_v = '0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      #2;
      cur = {alu, flags, err};
      if (held && out_valid && !rst) chk("hold_stable", 32'(cur), 32'(held_v));
      held   = out_valid && !out_ready && !rst;
      held_v = cur;
      if (!rst && out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_result: got %0h expected no output", cur);
        end else begin
          e = q.pop_front();
          chk("result", 32'(cur), 32'(e));
        end
      end
    end
  end

  initial begin
    int w, w2;
    rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; op_in = '0;
    nm_valid = 1'b0; nm_a = '0; nm_b = '0; nm_op = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_alu", alu, 0);
    chk("rst_flags", flags, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst = 1'b0;

    // directed single-cycle vectors
    rdy_mode = 1;
    issue(8'hFF, 8'h01, 4'h0, w);
    chk("add_latency", out_valid, 1);
    chk("add_alu", alu, 8'h00);
    chk("add_flags", flags, 4'b1100);
    issue(8'h80, 8'h01, 4'h1, w);
    chk("throughput", w, 0);
    issue(8'h01, 8'h02, 4'h1, w);
    chk("throughput", w, 0);
    issue(8'h81, 8'h09, 4'h2, w);
    issue(8'h80, 8'h03, 4'h3, w);
    issue(8'h80, 8'h03, 4'h8, w);
    chk("sra_alu", alu, 8'hF0);
    issue(8'h80, 8'h01, 4'h9, w);
    issue(8'h80, 8'h01, 4'hA, w);

    // MUL latency and a held follower
    issue(8'h10, 8'h11, 4'hB, w);
    fork
      begin
        for (int k = 1; k <= 8; k++) begin
          @(posedge clk); #1;
          chk("mul_valid", out_valid, (k == 8) ? 1 : 0);
          if (k < 8) chk("mul_ready_low", in_ready, 0);
          else begin
            chk("mul_alu", alu, 8'h10);
            chk("mul_carry", flags[3], 1);
          end
        end
      end
      begin
        issue(8'h03, 8'h04, 4'h0, w2);
        chk("add_held", w2, 8);
      end
    join

    // backpressure: three ADDs with the consumer stalled
    repeat (3) @(negedge clk);
    rdy_mode = 0;
    issue(8'h11, 8'h22, 4'h0, w);
    fork
      begin
        issue(8'h20, 8'h05, 4'h0, w);
        issue(8'h40, 8'h06, 4'h0, w2);
        chk("drain_throughput", w2, 0);
      end
      begin
        repeat (3) begin
          @(negedge clk); #1;
          chk("bp_valid", out_valid, 1);
          chk("bp_alu", alu, 8'h33);
          chk("bp_ready_low", in_ready, 0);
        end
        rdy_mode = 1;
      end
    join

    // async reset in the middle of a MUL
    repeat (3) @(negedge clk);
    issue(8'h05, 8'h06, 4'hB, w);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midmul_rst_valid", out_valid, 0);
    chk("midmul_rst_alu", alu, 0);
    chk("midmul_rst_flags", flags, 0);
    q.delete();
    @(negedge clk); rst = 1'b0;
    issue(8'h03, 8'h04, 4'h0, w);
    chk("post_rst_add", alu, 8'h07);

    // illegal opcode
    issue(8'h5A, 8'h33, 4'hC, w);
    chk("illegal_alu", alu, 0);
    chk("illegal_err", err, 1);

    // MUL disabled build: op B is illegal with 1-cycle latency
    @(negedge clk);
    nm_valid = 1'b1; nm_op = 4'hB; nm_a = 8'h10; nm_b = 8'h11;
    #1 chk("nomul_ready", nm_in_ready, 1);
    @(posedge clk); #1;
    nm_valid = 1'b0;
    n_vec++;
    chk("nomul_valid", nm_out_valid, 1);
    chk("nomul_err", nm_err, 1);
    chk("nomul_alu", nm_alu, 0);
    chk("nomul_flags", nm_flags, 0);

    // randomized traffic with random backpressure
    rdy_mode = 2;
    repeat (300) begin
      issue(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), w);
      if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    rdy_mode = 1;
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
